// File: rtl/mrf_load_ctrl.sv
// mrf_load_ctrl
//   Write-side controller for the matrix register file bank array. Takes a
//   load command (base address, word count) and a valid/ready weight stream,
//   and spreads the words round-robin across NUM_RAMS banks: word k goes to
//   bank k % NUM_RAMS at address base + k / NUM_RAMS (wrapping mod 2^AW).
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   cfg_valid/ready : command handshake; cfg_base_addr, cfg_len command fields
//   in_valid/ready  : weight stream handshake; in_data stream word
//   mrf_wr_en       : one-hot bank write enable (registered, 1-cycle pulse)
//   mrf_wr_addr     : shared bank write address (registered)
//   mrf_wr_data     : shared bank write data (registered)
//   done            : 1-cycle pulse when the command completes
//   busy            : high while a command is loading
module mrf_load_ctrl #(
  parameter int DW       = 32,
  parameter int AW       = 9,
  parameter int NUM_RAMS = 4,
  parameter int LW       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [AW-1:0]       cfg_base_addr,
  input  logic [LW-1:0]       cfg_len,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW-1:0]       in_data,
  output logic [NUM_RAMS-1:0] mrf_wr_en,
  output logic [AW-1:0]       mrf_wr_addr,
  output logic [DW-1:0]       mrf_wr_data,
  output logic                done,
  output logic                busy
);

  // Bank index needs at least one bit even for a single bank.
  localparam int BW = (NUM_RAMS > 1) ? $clog2(NUM_RAMS) : 1;

  typedef enum logic {IDLE, LOAD} state_e;

  state_e              state_q;
  logic [AW-1:0]       base_q;
  logic [AW-1:0]       off_q;
  logic [LW-1:0]       rem_q;
  logic [BW-1:0]       bank_q;
  logic [NUM_RAMS-1:0] wr_en_q;
  logic [AW-1:0]       wr_addr_q;
  logic [DW-1:0]       wr_data_q;
  logic                done_q;

  logic                cfg_acc;
  logic                in_acc;
  logic                bank_last;
  logic [NUM_RAMS-1:0] bank_sel;

  // Handshakes depend on the state register only.
  assign cfg_ready = (state_q == IDLE);
  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q == LOAD);

  assign cfg_acc   = cfg_valid && cfg_ready;
  assign in_acc    = in_valid && in_ready;
  assign bank_last = (bank_q == BW'(NUM_RAMS - 1));

  // One-hot decode of the current bank, qualified by the stream accept.
  for (genvar g = 0; g < NUM_RAMS; g++) begin : g_bank_sel
    assign bank_sel[g] = in_acc && (bank_q == BW'(g));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      off_q     <= '0;
      rem_q     <= '0;
      bank_q    <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      // Write enable and done are single-cycle pulses; address/data just
      // hold their last value when no write is issued.
      wr_en_q <= '0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_acc) begin
            base_q <= cfg_base_addr;
            rem_q  <= cfg_len;
            bank_q <= '0;
            off_q  <= '0;
            if (cfg_len == '0) done_q  <= 1'b1;
            else               state_q <= LOAD;
          end
        end
        LOAD: begin
          if (in_acc) begin
            wr_en_q   <= bank_sel;
            wr_addr_q <= base_q + off_q;   // wraps mod 2^AW by truncation
            wr_data_q <= in_data;
            bank_q    <= bank_last ? '0 : bank_q + BW'(1);
            if (bank_last) off_q <= off_q + AW'(1);
            rem_q     <= rem_q - LW'(1);
            if (rem_q == LW'(1)) begin
              state_q <= IDLE;
              done_q  <= 1'b1;             // coincides with the last write
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mrf_wr_en   = wr_en_q;
  assign mrf_wr_addr = wr_addr_q;
  assign mrf_wr_data = wr_data_q;
  assign done        = done_q;

endmodule

// File: tb/tb_mrf_load_ctrl.sv
module tb_mrf_load_ctrl;
  localparam int DW = 32, AW = 9, N = 4, LW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [AW-1:0] cfg_base_addr = '0;
  logic [LW-1:0] cfg_len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [N-1:0]  mrf_wr_en;
  logic [AW-1:0] mrf_wr_addr;
  logic [DW-1:0] mrf_wr_data;
  logic          done;
  logic          busy;

  mrf_load_ctrl #(.DW(DW), .AW(AW), .NUM_RAMS(N), .LW(LW)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_base_addr(cfg_base_addr), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mrf_wr_en(mrf_wr_en), .mrf_wr_addr(mrf_wr_addr), .mrf_wr_data(mrf_wr_data),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the command as (base, len, words taken so far) and places word k
  // at bank k%N, address (base + k/N) mod 2^AW.
  logic          m_busy = 1'b0;
  logic          started = 1'b0;
  logic [AW-1:0] m_base;
  int            m_len, m_k;
  logic [N-1:0]  exp_en;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  logic          exp_done;
  logic          chk_ad;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      started  <= 1'b1;
      m_busy   <= 1'b0;
      exp_en   <= '0;
      exp_addr <= '0;
      exp_data <= '0;
      exp_done <= 1'b0;
      chk_ad   <= 1'b1;
    end else begin
      exp_en   <= '0;
      exp_done <= 1'b0;
      chk_ad   <= 1'b0;
      if (!m_busy) begin
        if (cfg_valid) begin
          m_base <= cfg_base_addr;
          m_len  <= int'(cfg_len);
          m_k    <= 0;
          if (cfg_len == '0) exp_done <= 1'b1;
          else               m_busy   <= 1'b1;
        end
      end else if (in_valid) begin
        exp_en   <= N'(1) << (m_k % N);
        exp_addr <= AW'((int'(m_base) + m_k / N) % (1 << AW));
        exp_data <= in_data;
        chk_ad   <= 1'b1;
        m_k      <= m_k + 1;
        if (m_k + 1 == m_len) begin
          m_busy   <= 1'b0;
          exp_done <= 1'b1;
        end
      end
    end
  end

  // Write / done log used by the literal checks.
  int q_bank[$], q_addr[$], q_data[$], q_cyc[$], d_cyc[$];

  always @(negedge clk) begin
    if (started) begin
      chk("wr_en",     64'(mrf_wr_en), 64'(exp_en));
      chk("done",      64'(done),      64'(exp_done));
      chk("busy",      64'(busy),      64'(m_busy));
      chk("cfg_ready", 64'(cfg_ready), 64'(!m_busy));
      chk("in_ready",  64'(in_ready),  64'(m_busy));
      if (chk_ad) begin
        chk("wr_addr", 64'(mrf_wr_addr), 64'(exp_addr));
        chk("wr_data", 64'(mrf_wr_data), 64'(exp_data));
      end
      if (mrf_wr_en != '0) begin
        int bk = 0;
        for (int i = 0; i < N; i++) if (mrf_wr_en[i]) bk = i;
        q_bank.push_back(bk);
        q_addr.push_back(int'(mrf_wr_addr));
        q_data.push_back(int'(mrf_wr_data));
        q_cyc.push_back(cyc);
      end
      if (done) d_cyc.push_back(cyc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_log();
    q_bank.delete(); q_addr.delete(); q_data.delete(); q_cyc.delete(); d_cyc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cmd(input logic [AW-1:0] base, input logic [LW-1:0] len);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_base_addr = base; cfg_len = len;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Sends n words (d0, d0+1, ...); with gaps, in_valid toggles 1,0,1,0...
  task automatic send(input int n, input bit gaps, input logic [DW-1:0] d0);
    int sent = 0;
    int c = 0;
    while (sent < n && c < 200) begin
      in_valid = gaps ? (c % 2 == 0) : 1'b1;
      in_data  = d0 + DW'(sent);
      if (in_valid && in_ready) sent++;
      c++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (sent < n) chk("send_timeout", 64'(sent), 64'(n));
  endtask

  initial begin
    idle(2);
    rst = 1'b0;
    idle(1);

    // Basic load
    clear_log();
    cmd(9'h010, 8);
    send(8, 0, 0);
    idle(3);
    chk("basic_count", 64'(q_bank.size()), 8);
    chk("basic_b3",    64'(q_bank[3]), 3);
    chk("basic_b4",    64'(q_bank[4]), 0);
    chk("basic_a4",    64'(q_addr[4]), 64'h011);
    chk("basic_d7",    64'(q_data[7]), 7);
    chk("basic_done",  64'(d_cyc[0]), 64'(q_cyc[7]));

    // Stream gaps
    clear_log();
    cmd(9'h040, 5);
    send(5, 1, 32'h100);
    idle(3);
    chk("gap_count", 64'(q_bank.size()), 5);
    chk("gap_space", 64'(q_cyc[1] - q_cyc[0]), 2);
    chk("gap_b4",    64'(q_bank[4]), 0);
    chk("gap_a4",    64'(q_addr[4]), 64'h041);
    chk("gap_done",  64'(d_cyc[0]), 64'(q_cyc[4]));

    // Address wrap
    clear_log();
    cmd(9'h1FF, 8);
    send(8, 0, 32'h200);
    idle(3);
    chk("wrap_a3", 64'(q_addr[3]), 64'h1FF);
    chk("wrap_a4", 64'(q_addr[4]), 0);
    chk("wrap_b7", 64'(q_bank[7]), 3);

    // Zero length
    clear_log();
    cmd(9'h050, 0);
    idle(3);
    chk("zero_writes", 64'(q_bank.size()), 0);
    chk("zero_done",   64'(d_cyc.size()), 1);

    // Back-to-back commands, both pending; stream held valid throughout
    clear_log();
    begin
      int phase = 0;
      int words = 0;
      int c = 0;
      @(negedge clk);
      cfg_valid = 1'b1; cfg_base_addr = 9'h020; cfg_len = 3;
      in_valid = 1'b1; in_data = 32'h300;
      while (!(phase == 2 && words == 5) && c < 40) begin
        bit ca, ia;
        ca = cfg_valid && cfg_ready;
        ia = in_valid && in_ready;
        @(negedge clk);
        c++;
        if (ca) begin
          phase++;
          if (phase == 1) begin cfg_base_addr = 9'h100; cfg_len = 2; end
          else cfg_valid = 1'b0;
        end
        if (ia) begin words++; in_data = in_data + 1; end
        if (words == 5) in_valid = 1'b0;
      end
      cfg_valid = 1'b0; in_valid = 1'b0;
      if (c >= 40) chk("b2b_timeout", 64'(c), 0);
    end
    idle(3);
    chk("b2b_count",   64'(q_bank.size()), 5);
    chk("b2b_b3",      64'(q_bank[3]), 0);
    chk("b2b_a3",      64'(q_addr[3]), 64'h100);
    chk("b2b_timing",  64'(q_cyc[3]), 64'(d_cyc[0] + 2));

    // Reset mid-load
    clear_log();
    cmd(9'h000, 10);
    send(3, 0, 32'h400);
    idle(1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    chk("rst_writes", 64'(q_bank.size()), 3);
    chk("rst_nodone", 64'(d_cyc.size()), 0);
    cmd(9'h030, 2);
    send(2, 0, 32'h500);
    idle(3);
    chk("rst_b3", 64'(q_bank[3]), 0);
    chk("rst_a3", 64'(q_addr[3]), 64'h030);
    chk("rst_b4", 64'(q_bank[4]), 1);
    chk("rst_a4", 64'(q_addr[4]), 64'h030);
    chk("rst_done", 64'(d_cyc.size()), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mrf_load_ctrl.md
# mrf_load_ctrl

Write-side controller for the matrix register file banks. It accepts a load command (base address, word count) and a valid/ready stream of weight words, and distributes the words round-robin across `NUM_RAMS` `mrf_ram` instances. Each word is presented as a registered write (`wr_en`/`wr_addr`/`wr_data`) to the bank's write port. It sits between the instruction/weight-loading path and the MRF bank array.

## Interface

Parameters:
- `DW`, 32: data word width, equal to the `mrf_ram` `DW`.
- `AW`, 9: bank address width, equal to the `mrf_ram` `AW`.
- `NUM_RAMS`, 4: number of banks fed; must be a power of two and at least 1.
- `LW`, 16: width of the word-count field.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `cfg_valid` in 1: load command valid.
- `cfg_ready` out 1: controller can accept a command.
- `cfg_base_addr` in AW: starting bank address.
- `cfg_len` in LW: number of words to load.
- `in_valid` in 1: stream word valid.
- `in_ready` out 1: controller accepts stream word.
- `in_data` in DW: stream word.
- `mrf_wr_en` out NUM_RAMS: one-hot per-bank write enable.
- `mrf_wr_addr` out AW: write address, shared by all banks.
- `mrf_wr_data` out DW: write data, shared by all banks.
- `done` out 1: one-cycle pulse when the command has completed.
- `busy` out 1: high while a command is in progress (state LOAD).

## Operation

- FSM has two states, IDLE and LOAD.
- IDLE:
  - `cfg_ready`=1, `in_ready`=0.
  - A command is accepted when `cfg_valid`&&`cfg_ready`. On accept, latch `base`, `remaining`=`cfg_len`, bank index `b`=0, offset `o`=0.
  - If `cfg_len`==0: stay in IDLE and assert `done` the next cycle. No writes are issued.
  - Otherwise go to LOAD.
- LOAD:
  - `cfg_ready`=0, `in_ready`=1. Input `cfg_valid` is ignored.
  - Each accepted word (`in_valid`&&`in_ready`) with index k, counted from 0, goes to bank `k % NUM_RAMS` at address `(base + k/NUM_RAMS) mod 2^AW`. The address wraps silently from 2^AW-1 to 0.
  - After each accept: `b` increments. When `b` wraps from NUM_RAMS-1 to 0, `o` increments. `remaining` decrements.
  - On the accept that brings `remaining` to 0, go to IDLE.
- `in_valid` while in IDLE is not consumed; the data is held upstream.
- Reset (at any time, including mid-LOAD):
  - State returns to IDLE.
  - Outputs are cleared: `mrf_wr_en`=0, `mrf_wr_addr`=0, `mrf_wr_data`=0, `done`=0, `busy`=0, `in_ready`=0.
  - `cfg_ready`=1 from the first cycle after reset deasserts.
  - No `done` is issued for the aborted command. Words already written stay in the RAMs.

## Timing

- Write latency: a stream word accepted at cycle t appears on `mrf_wr_en`/`mrf_wr_addr`/`mrf_wr_data` at cycle t+1. These are registered outputs, held for exactly one cycle.
- `mrf_wr_en` is all-zero in any cycle that follows a cycle with no accept.
- Throughput is one word per cycle; the block never back-pressures inside LOAD.
- Completion:
  - `done` pulses at t+1 of the final accept, coincident with the last write.
  - For `cfg_len`==0, `done` pulses at t+1 of the command accept.
- `cfg_ready` and `in_ready` are combinational from the state register only; they do not depend on `cfg_valid` or `in_valid`.
- A new command can be accepted at t+1 after the final word accept. Back-to-back commands therefore leave one bubble cycle between streams.
- Write data reaches the bank array one cycle later than a direct connection would. This means `mrf_ram` read-during-write behaviour ("DONT_CARE") is the consumer's concern; this block makes no guarantee about reads of in-flight addresses.
- `remaining` is LW bits wide. `cfg_len` up to 2^LW-1 is legal. Lengths above NUM_RAMS·2^AW wrap addresses and overwrite earlier words; this is permitted and not flagged.

## Test plan

- Basic load, NUM_RAMS=4: base=0x010, len=8, `in_valid` held high with data 0..7 → writes bank0@0x010=0, bank1@0x010=1, bank2@0x010=2, bank3@0x010=3, bank0@0x011=4, …, bank3@0x011=7 on 8 consecutive cycles. `done` coincides with the last write.
- Stream gaps: len=5, `in_valid` toggled 1,0,1,0,… → `mrf_wr_en` is non-zero only on the cycle after each accept. Addresses and bank order are the same as with no gaps. `done` comes after the 5th write.
- Address wrap: base=0x1FF, len=8 → bank writes 0–3 go to address 0x1FF and writes 4–7 go to address 0x000.
- Zero length: `cfg_valid` with len=0 → no `mrf_wr_en`, `done` 1 cycle later, `cfg_ready` stays 1.
- Back-to-back: command A (len=3) then command B (len=2, base=0x100), both pending → B is accepted on the cycle of A's `done`, and B's first word goes to bank0@0x100.
- Reset mid-load: `rst` asserted after 3 of 10 words → next cycle all outputs are 0 and `cfg_ready`=1. No `done` appears. A following command with len=2 behaves like the basic load.
